// File: rtl/step_seq_gen_pkg.sv
// Shared definitions for the step-enable sequencer: state encoding and the
// step/latency defaults also used by the downstream step counter.
package step_seq_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_t;

  // 3x3 kernel: nine steps per operation; the counter registers CE twice.
  localparam int DEF_NUM_STEPS = 9;
  localparam int DEF_CE_LAT    = 2;
  localparam int DEF_CNT_W     = 5;
  localparam int DRAIN_W       = 3;

endpackage

// File: rtl/step_seq_gen_if.sv
// Control/status bundle between the extension decode, the sequencer and the
// kernel datapath. START/STALL/ABORT are level inputs sampled every rising
// edge; CE/CNT_RST/DONE are single-cycle pulses; STEP_IDX is meaningful only
// while STEP_VLD is high. No ready/backpressure path exists beyond STALL.
interface step_seq_gen_if #(
  parameter int CNT_W = 5
);
  logic             START;
  logic             STALL;
  logic             ABORT;
  logic             CE;
  logic             CNT_RST;
  logic [CNT_W-1:0] STEP_IDX;
  logic             STEP_VLD;
  logic             BUSY;
  logic             DONE;

  modport master (
    output START, STALL, ABORT,
    input  CE, CNT_RST, STEP_IDX, STEP_VLD, BUSY, DONE
  );

  modport slave (
    input  START, STALL, ABORT,
    output CE, CNT_RST, STEP_IDX, STEP_VLD, BUSY, DONE
  );
endinterface

// File: rtl/step_seq_gen_delay_line.sv
// CE_LAT-deep shift register of {valid, index}; its tail lines up with the
// cycle in which the downstream counter actually increments.
module step_delay_line #(
  parameter int CE_LAT = 2,
  parameter int CNT_W  = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [CNT_W-1:0] idx_i,
  output logic             vld_o,
  output logic [CNT_W-1:0] idx_o
);
  localparam int IW = CE_LAT * CNT_W;

  logic [CE_LAT-1:0] vld_q, vld_d;
  logic [IW-1:0]     idx_q, idx_d;

  // Stage 0 sits in the low bits; the cast drops the stage falling off the top.
  always_comb begin
    vld_d = CE_LAT'({vld_q, vld_i});
    idx_d = IW'({idx_q, idx_i});
    if (flush_i) begin
      vld_d = '0;
      idx_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      idx_q <= '0;
    end else begin
      vld_q <= vld_d;
      idx_q <= idx_d;
    end
  end

  assign vld_o = vld_q[CE_LAT-1];
  assign idx_o = idx_q[IW-1 -: CNT_W];

endmodule

// File: rtl/step_seq_gen.sv
// Issues NUM_STEPS registered CE pulses per START and produces a step-index
// stream aligned to the downstream counter's CE_LAT-cycle increment lag.
module step_seq_gen
  import step_seq_gen_pkg::*;
#(
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int CE_LAT    = DEF_CE_LAT
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  step_seq_gen_if.slave        bus,
  output state_t               dbg_state_o
);
  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(NUM_STEPS - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(CE_LAT - 1);

  state_t              state_q, state_d;
  logic                issue_ce;
  logic                flush;
  logic                cnt_rst;
  logic                busy;
  logic                done;
  logic                ce_q, ce_d;
  logic [CNT_W-1:0]    ce_idx_q, ce_idx_d;
  logic [CNT_W-1:0]    issue_cnt_q, issue_cnt_d;
  logic                all_issued_q, all_issued_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // RUN spans exactly the cycles in which CE is visible; it is left once the
  // final pulse has been driven.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.START) state_d = ST_CLR;
      ST_CLR:   state_d = ST_RUN;
      ST_RUN:   if (ce_q && all_issued_q) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_cnt_q == DRAIN_LAST) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (bus.ABORT) state_d = ST_IDLE;
  end

  // The CLR cycle makes the first issue decision so the pulse lands right
  // after the counter clear; STALL only gates decisions taken in RUN.
  always_comb begin
    issue_ce = 1'b0;
    flush    = 1'b0;
    cnt_rst  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    if (state_q != ST_IDLE) begin
      busy  = 1'b1;
      flush = bus.ABORT;
    end
    if (state_q == ST_CLR) cnt_rst = 1'b1;
    if (state_q == ST_FIN) done = 1'b1;
    if (!bus.ABORT) begin
      if (state_q == ST_CLR) issue_ce = 1'b1;
      if (state_q == ST_RUN && !bus.STALL && !all_issued_q) issue_ce = 1'b1;
    end
  end

  always_comb begin
    ce_d         = issue_ce;
    ce_idx_d     = issue_ce ? issue_cnt_q : ce_idx_q;
    issue_cnt_d  = issue_cnt_q;
    all_issued_d = all_issued_q;
    drain_cnt_d  = (state_q == ST_DRAIN) ? drain_cnt_q + 1'b1 : '0;
    if (state_q == ST_IDLE) begin
      issue_cnt_d  = '0;
      all_issued_d = 1'b0;
    end else if (issue_ce) begin
      issue_cnt_d = issue_cnt_q + 1'b1;
      if (issue_cnt_q == LAST_IDX) all_issued_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ce_q         <= 1'b0;
      ce_idx_q     <= '0;
      issue_cnt_q  <= '0;
      all_issued_q <= 1'b0;
      drain_cnt_q  <= '0;
    end else begin
      ce_q         <= ce_d;
      ce_idx_q     <= ce_idx_d;
      issue_cnt_q  <= issue_cnt_d;
      all_issued_q <= all_issued_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  step_delay_line #(
    .CE_LAT (CE_LAT),
    .CNT_W  (CNT_W)
  ) u_delay (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .flush_i (flush),
    .vld_i   (ce_q),
    .idx_i   (ce_idx_q),
    .vld_o   (bus.STEP_VLD),
    .idx_o   (bus.STEP_IDX)
  );

  assign bus.CE      = ce_q;
  assign bus.CNT_RST = cnt_rst;
  assign bus.BUSY    = busy;
  assign bus.DONE    = done;
  assign dbg_state_o = state_q;

  ce_only_in_run: assert property (@(posedge CLK) disable iff (!RST_N)
    ce_q |-> (state_q == ST_RUN));

endmodule

// File: tb/tb_step_seq_gen.sv
// Directed bench for step_seq_gen: a 9-step/2-lag instance with a model of
// the downstream step counter, plus a 1-step/1-lag instance for the limits.
module tb_step_seq_gen;
  import step_seq_gen_pkg::*;

  localparam int CNT_W = 5;
  localparam int NA    = 9;
  localparam int LA    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  step_seq_gen_if #(.CNT_W(CNT_W)) bus_a ();
  step_seq_gen_if #(.CNT_W(CNT_W)) bus_b ();
  state_t st_a, st_b;

  step_seq_gen #(.NUM_STEPS(NA), .CNT_W(CNT_W), .CE_LAT(LA)) dut_a (
    .CLK(clk), .RST_N(rst_n), .bus(bus_a), .dbg_state_o(st_a)
  );
  step_seq_gen #(.NUM_STEPS(1), .CNT_W(CNT_W), .CE_LAT(1)) dut_b (
    .CLK(clk), .RST_N(rst_n), .bus(bus_b), .dbg_state_o(st_b)
  );

  int total = 0;
  int bad   = 0;

  // Downstream counter: CE is registered twice before it increments.
  logic             ds_ce1, ds_ce2;
  logic [CNT_W-1:0] ds_cnt;
  int               ce_seen;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ds_ce1 <= 1'b0; ds_ce2 <= 1'b0; ds_cnt <= '0; ce_seen <= 0;
    end else begin
      ds_ce1 <= bus_a.CE;
      ds_ce2 <= ds_ce1;
      if (bus_a.CNT_RST) ds_cnt <= '0;
      else if (ds_ce2)   ds_cnt <= ds_cnt + 1'b1;
      if (bus_a.CNT_RST) ce_seen <= 0;
      else if (bus_a.CE) ce_seen <= ce_seen + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input logic [31:0] m, input int k);
    return m[k[4:0]];
  endfunction

  // One operation on instance A; masks are indexed by cycle offset from START.
  task automatic run_seq(input string tag, input logic [31:0] ce_m, input logic [31:0] stall_m,
                         input logic [31:0] start_m, input int done_off);
    logic [31:0] vld_m;
    int exp_idx, prev_idx;
    logic prev_vld;
    vld_m = ce_m << LA;
    exp_idx = 0; prev_idx = 0; prev_vld = 1'b0;
    for (int k = 0; k <= done_off + 1; k++) begin
      bus_a.START = bit_at(start_m, k);
      bus_a.STALL = bit_at(stall_m, k);
      chk({tag, ".cnt_rst"}, 32'(bus_a.CNT_RST), 32'(k == 1));
      chk({tag, ".ce"},      32'(bus_a.CE),      32'(bit_at(ce_m, k)));
      chk({tag, ".vld"},     32'(bus_a.STEP_VLD), 32'(bit_at(vld_m, k)));
      if (bit_at(vld_m, k)) chk({tag, ".idx"}, 32'(bus_a.STEP_IDX), exp_idx);
      chk({tag, ".done"},    32'(bus_a.DONE), 32'(k == done_off));
      chk({tag, ".busy"},    32'(bus_a.BUSY), 32'(k >= 1 && k <= done_off));
      if (prev_vld) chk({tag, ".ds_cnt"}, 32'(ds_cnt), prev_idx + 1);
      if (k == done_off) begin
        chk({tag, ".ds_cnt_done"}, 32'(ds_cnt), NA);
        chk({tag, ".ce_count"}, ce_seen, NA);
      end
      prev_vld = bit_at(vld_m, k);
      prev_idx = exp_idx;
      if (bit_at(vld_m, k)) exp_idx++;
      tick();
    end
    bus_a.START = 1'b0;
    bus_a.STALL = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.START = 1'b0; bus_a.STALL = 1'b0; bus_a.ABORT = 1'b0;
    bus_b.START = 1'b0; bus_b.STALL = 1'b0; bus_b.ABORT = 1'b0;
    #1;

    // Reset held for three cycles with one START pulse inside it.
    for (int i = 0; i < 3; i++) begin
      bus_a.START = (i == 1);
      bus_b.START = (i == 1);
      tick();
      chk("rst.ce",      32'(bus_a.CE), 0);
      chk("rst.cnt_rst", 32'(bus_a.CNT_RST), 0);
      chk("rst.vld",     32'(bus_a.STEP_VLD), 0);
      chk("rst.busy",    32'(bus_a.BUSY), 0);
      chk("rst.done",    32'(bus_a.DONE), 0);
      chk("rst.state",   32'(st_a), 32'(ST_IDLE));
      chk("rst.b_busy",  32'(bus_b.BUSY), 0);
    end
    bus_a.START = 1'b0;
    bus_b.START = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst.ce",   32'(bus_a.CE), 0);
      chk("post_rst.busy", 32'(bus_a.BUSY), 0);
    end

    // Nominal run; extra START pulses in RUN (offset 5) and FIN (13) are ignored.
    run_seq("nom", 32'h0000_07FC, 32'h0, 32'h0000_2021, 13);
    tick();

    // STALL over offsets 4..6 opens a 3-cycle CE gap; DONE moves to offset 16.
    run_seq("stall", 32'h0000_3F1C, 32'h0000_0070, 32'h1, 16);
    tick();

    // Asynchronous reset in the middle of RUN.
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.ce",    32'(bus_a.CE), 0);
    chk("mid_rst.vld",   32'(bus_a.STEP_VLD), 0);
    chk("mid_rst.busy",  32'(bus_a.BUSY), 0);
    chk("mid_rst.state", 32'(st_a), 32'(ST_IDLE));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst.idle_done", 32'(bus_a.DONE), 0);
    end

    // ABORT on the 5th CE cycle (offset 6).
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("abort.ce5", 32'(bus_a.CE), 1);
    bus_a.ABORT = 1'b1;
    tick();
    bus_a.ABORT = 1'b0;
    chk("abort.ce",    32'(bus_a.CE), 0);
    chk("abort.vld",   32'(bus_a.STEP_VLD), 0);
    chk("abort.busy",  32'(bus_a.BUSY), 0);
    chk("abort.state", 32'(st_a), 32'(ST_IDLE));
    for (int i = 0; i < 12; i++) begin
      chk("abort.no_done", 32'(bus_a.DONE), 0);
      tick();
    end
    run_seq("rerun", 32'h0000_07FC, 32'h0, 32'h1, 13);
    tick();

    // START and ABORT together in IDLE: stays idle.
    bus_a.START = 1'b1;
    bus_a.ABORT = 1'b1;
    tick();
    bus_a.START = 1'b0;
    bus_a.ABORT = 1'b0;
    chk("idle_abort.busy",    32'(bus_a.BUSY), 0);
    chk("idle_abort.cnt_rst", 32'(bus_a.CNT_RST), 0);
    chk("idle_abort.state",   32'(st_a), 32'(ST_IDLE));
    tick();
    chk("idle_abort.ce", 32'(bus_a.CE), 0);

    // Single step, single-cycle lag.
    bus_b.START = 1'b1;
    tick();
    bus_b.START = 1'b0;
    chk("one.cnt_rst", 32'(bus_b.CNT_RST), 1);
    chk("one.ce_clr",  32'(bus_b.CE), 0);
    tick();
    chk("one.ce",      32'(bus_b.CE), 1);
    chk("one.vld_early", 32'(bus_b.STEP_VLD), 0);
    tick();
    chk("one.ce_off",  32'(bus_b.CE), 0);
    chk("one.vld",     32'(bus_b.STEP_VLD), 1);
    chk("one.idx",     32'(bus_b.STEP_IDX), 0);
    chk("one.done_early", 32'(bus_b.DONE), 0);
    tick();
    chk("one.done",    32'(bus_b.DONE), 1);
    chk("one.vld_off", 32'(bus_b.STEP_VLD), 0);
    chk("one.busy_fin", 32'(bus_b.BUSY), 1);
    tick();
    chk("one.idle_busy", 32'(bus_b.BUSY), 0);
    chk("one.idle_done", 32'(bus_b.DONE), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
